// File: rtl/bias_update_ctrl.sv
// Bias-update sequencer: per neuron reads the old bias, waits for its delta, strobes the
// datapath result register and writes the new bias back. Optional macro: BIAS_SAT_EN.
module bias_update_ctrl #(
  parameter int                        DWIDTH       = 16,
  parameter int                        AWIDTH       = 10,
  parameter int                        HiddenNeuron = 16,
  parameter int                        OutNeuron    = 4,
  parameter int                        Layer        = 3,
  parameter logic signed [DWIDTH-1:0]  BIAS_LIMIT   = 16'sd16384
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        layer_sel,
  input  logic              delta_valid,
  input  logic [DWIDTH-1:0] new_bias,
  output logic              bram_en,
  output logic              bram_we,
  output logic [AWIDTH-1:0] bram_addr,
  output logic [DWIDTH-1:0] bram_din,
  output logic [AWIDTH-1:0] delta_addr,
  output logic              en_b_back,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_CALC,
    S_WRITE,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [AWIDTH-1:0] n_q, n_d;
  logic [AWIDTH-1:0] base_q, base_d;
  logic [AWIDTH-1:0] count_q, count_d;
  logic [DWIDTH-1:0] wr_data;
  logic              layer_ok;
  logic              last_neuron;

  assign layer_ok    = (32'(layer_sel) < 32'(Layer));
  assign last_neuron = (n_q == (count_q - AWIDTH'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      base_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      base_q  <= base_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    base_d  = base_q;
    count_d = count_q;
    unique case (state_q)
      S_IDLE: begin
        // Out-of-range layer indices are dropped so no BRAM traffic is generated
        if (start && layer_ok) begin
          n_d     = '0;
          base_d  = AWIDTH'(32'(layer_sel) * HiddenNeuron);
          count_d = (32'(layer_sel) == 32'(Layer - 1)) ? AWIDTH'(OutNeuron)
                                                       : AWIDTH'(HiddenNeuron);
          state_d = S_READ;
        end
      end
      S_READ:  state_d = S_WAIT;
      S_WAIT: begin
        if (delta_valid) begin
          state_d = S_CALC;
        end
      end
      S_CALC:  state_d = S_WRITE;
      S_WRITE: begin
        if (last_neuron) begin
          state_d = S_DONE;
        end else begin
          n_d     = n_q + AWIDTH'(1);
          state_d = S_READ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

`ifdef BIAS_SAT_EN
  logic signed [DWIDTH-1:0] nb_s;

  always_comb begin
    nb_s    = signed'(new_bias);
    wr_data = new_bias;
    if (nb_s > BIAS_LIMIT) begin
      wr_data = BIAS_LIMIT;
    end else if (nb_s < -BIAS_LIMIT) begin
      wr_data = -BIAS_LIMIT;
    end
  end
`else
  logic unused_limit;

  assign unused_limit = ^BIAS_LIMIT;
  assign wr_data      = new_bias;
`endif

  // Addresses come straight from the held base/counter, so they keep their value in IDLE
  always_comb begin
    bram_en    = (state_q == S_READ) || (state_q == S_WRITE);
    bram_we    = (state_q == S_WRITE);
    bram_addr  = base_q + n_q;
    delta_addr = n_q;
    bram_din   = (state_q == S_WRITE) ? wr_data : '0;
    en_b_back  = (state_q == S_CALC);
    busy       = (state_q != S_IDLE);
    done       = (state_q == S_DONE);
  end

endmodule

// File: doc/bias_update_ctrl.md
# bias_update_ctrl

Sequencer for the back-propagation bias-update datapath. On a start request for one layer it walks every neuron of that layer. For each neuron it reads the old bias from the bias BRAM, waits for that neuron's delta, pulses the update-register enable of the bias datapath (learning-rate multiply plus add), and writes the registered new bias back to the same BRAM address. It sits between the training-phase top-level FSM and the bias BRAM/datapath pair.

## Interface
- DWIDTH, 16, bias/delta word width (signed)
- AWIDTH, 10, BRAM and delta-buffer address width
- HiddenNeuron, 16, neurons per hidden layer
- OutNeuron, 4, neurons in the output layer
- Layer, 3, number of bias-carrying layers; index Layer-1 is the output layer
- BIAS_LIMIT, 16'sd16384, saturation magnitude; used only with BIAS_SAT_EN

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- layer_sel  in  2  layer index 0..Layer-1, latched with start
- delta_valid  in  1  delta word for the current delta_addr is present
- new_bias  in  DWIDTH  registered result from the bias datapath
- bram_en  out  1  BRAM port enable
- bram_we  out  1  BRAM write enable
- bram_addr  out  AWIDTH  bias BRAM address
- bram_din  out  DWIDTH  write data
- delta_addr  out  AWIDTH  delta-buffer read address
- en_b_back  out  1  capture enable for the datapath result register
- busy  out  1  high from start acceptance until DONE exits
- done  out  1  one-cycle pulse at end of layer

## Operation
- States: IDLE, READ, WAIT, CALC, WRITE, DONE.
- IDLE:
  - On start=1, latch layer_sel and clear the neuron counter n.
  - base = layer_sel*HiddenNeuron. count = OutNeuron if layer_sel==Layer-1, else HiddenNeuron.
  - Go to READ.
  - layer_sel >= Layer: start ignored, remain IDLE.
- READ: bram_en=1, bram_addr=base+n, delta_addr=n. Go to WAIT.
- WAIT: BRAM output valid this cycle; delta_addr held. If delta_valid=1, go to CALC; otherwise hold in WAIT, no timeout.
- CALC: en_b_back=1 for exactly one cycle. The datapath register captures old_bias+lr*delta at the end of this cycle. Go to WRITE.
- WRITE:
  - bram_en=1, bram_we=1, bram_addr=base+n, bram_din=new_bias.
  - If n==count-1, go to DONE; else n<=n+1 and go to READ.
- DONE: done=1 for one cycle, then IDLE.
- busy=1 in every state except IDLE.
- start while busy is ignored, not queued.
- Address arithmetic is unsigned AWIDTH, modulo 2^AWIDTH. The configured maximum (Layer*HiddenNeuron) must be < 2^AWIDTH.
- bram_addr and delta_addr hold their last value in IDLE; bram_din is 0 outside WRITE.

## Timing
- Reset (asynchronous assert, synchronous release): state=IDLE, n=0, all outputs 0.
- Reset mid-layer aborts immediately. Writes already done stay in BRAM. No partial write is issued, because bram_we drops asynchronously.
- Per neuron: 4 cycles plus WAIT stall cycles.
- Layer latency with delta_valid tied high: 4*count+1 cycles from the start-sample edge to the done pulse.
- All outputs are registered state decodes; no combinational path from inputs to outputs except bram_din from new_bias in WRITE.
- BRAM read latency is 1 cycle. new_bias is valid on the cycle after en_b_back.

## Configuration
- Macro BIAS_SAT_EN.
- Defined: in WRITE, bram_din = new_bias clamped to [-BIAS_LIMIT, +BIAS_LIMIT], signed compare.
- Undefined: bram_din = new_bias unmodified, wrap as produced by the datapath.

## Test plan
- Reset, start with layer_sel=0, delta_valid=1 -> addresses 0..15 read and written in order; done at cycle 65; busy high for cycles 1..65.
- start with layer_sel=2 -> base 32, count 4; writes to 32..35; done after 17 cycles.
- delta_valid held low 3 cycles in WAIT for neuron 5 -> state holds; en_b_back is not pulsed until delta_valid=1; total latency +3.
- start pulsed again while busy, plus layer_sel=3 in IDLE -> both ignored; no BRAM activity, busy stays as is.
- rst_n low during CALC of neuron 7 -> all outputs 0 immediately; BRAM addresses 0..6 written, address 7 untouched; next start restarts at n=0.
- With BIAS_SAT_EN, new_bias=16'sd20000 -> bram_din=16384; new_bias=-16'sd20000 -> -16384. Without the macro, both values pass through unchanged.
